// File: rtl/dmem_mmio_responder.sv
// Data-memory responder for the MEM-stage bus: byte-enabled RAM plus UART MMIO window
// (TX FIFO, RX holding register, status). Stalls the pipeline on a TX store into a full FIFO.
module dmem_mmio_responder #(
    parameter int unsigned RAM_WORDS = 1024,
    parameter int unsigned TX_DEPTH  = 8,
    parameter logic [31:0] MMIO_BASE = 32'hAAAAA000
) (
    input  logic        clk,
    input  logic        Rst_n,
    input  logic        dbg,
    input  logic        mem_wea,
    input  logic        mem_rea,
    input  logic [3:0]  mem_en,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_din,
    output logic [31:0] mem_dout,
    output logic        mem_hold,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid
);

    localparam int unsigned RAM_AW    = $clog2(RAM_WORDS);
    localparam int unsigned TX_AW     = $clog2(TX_DEPTH);
    localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);
    localparam logic [29:0] STATUS_WA = MMIO_BASE[31:2];
    localparam logic [29:0] TXDATA_WA = STATUS_WA + 30'd1;
    localparam logic [29:0] RXDATA_WA = STATUS_WA + 30'd2;

    logic [31:0]       ram_q [RAM_WORDS];
    logic [7:0]        tx_mem_q [TX_DEPTH];
    logic [TX_AW:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [7:0]        rx_byte_q, rx_byte_d;
    logic              rx_full_q, rx_full_d;
    logic              overrun_q, overrun_d;
    logic [31:0]       dout_q, dout_d;

    logic              hit_ram, hit_status, hit_tx, hit_rx;
    logic              fifo_full, fifo_empty;
    logic              accept, push, pop, rx_pop, status_rd, ram_we;
    logic [RAM_AW-1:0] ram_idx;
    logic [31:0]       wdata, rdata;

    // Address decode and handshake qualifiers
    assign hit_ram    = mem_addr < RAM_BYTES;
    assign hit_status = mem_addr[31:2] == STATUS_WA;
    assign hit_tx     = mem_addr[31:2] == TXDATA_WA;
    assign hit_rx     = mem_addr[31:2] == RXDATA_WA;
    assign ram_idx    = mem_addr[RAM_AW+1:2];

    assign fifo_empty = wr_ptr_q == rd_ptr_q;
    assign fifo_full  = (wr_ptr_q[TX_AW] != rd_ptr_q[TX_AW]) &&
                        (wr_ptr_q[TX_AW-1:0] == rd_ptr_q[TX_AW-1:0]);

    assign mem_hold  = mem_wea & hit_tx & mem_en[0] & fifo_full;
    assign accept    = !dbg && !mem_hold;
    assign push      = accept & mem_wea & hit_tx & mem_en[0];
    assign pop       = !fifo_empty & tx_ready;
    assign rx_pop    = accept & mem_rea & hit_rx;
    assign status_rd = accept & mem_rea & hit_status;
    assign ram_we    = accept & mem_wea & hit_ram;

    assign tx_valid  = !fifo_empty;
    assign tx_data   = tx_mem_q[rd_ptr_q[TX_AW-1:0]];
    assign mem_dout  = dout_q;

    // Rotate store data into its byte lanes; offset 3 halfwords wrap within the word
    always_comb begin
        wdata = mem_din;
        case (mem_addr[1:0])
            2'd1:    wdata = {mem_din[23:0], mem_din[31:24]};
            2'd2:    wdata = {mem_din[15:0], mem_din[31:16]};
            2'd3:    wdata = {mem_din[7:0],  mem_din[31:8]};
            default: wdata = mem_din;
        endcase
    end

    // Aligned read word for the addressed target
    always_comb begin
        rdata = 32'd0;
        if (hit_ram) begin
            rdata = ram_q[ram_idx];
        end else if (hit_status) begin
            rdata = {28'd0, overrun_q, rx_full_q, fifo_empty, fifo_full};
        end else if (hit_rx) begin
            rdata = {23'd0, rx_full_q, rx_byte_q};
        end
    end

    // Next-state for FIFO pointers, RX holding register, overrun flag and read data
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        rx_byte_d = rx_byte_q;
        rx_full_d = rx_full_q;
        overrun_d = overrun_q;
        dout_d    = dout_q;

        if (push) wr_ptr_d = wr_ptr_q + (TX_AW+1)'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + (TX_AW+1)'(1);

        // A pop frees the holding register in time for a coincident capture
        if (rx_valid && (!rx_full_q || rx_pop)) begin
            rx_byte_d = rx_data;
            rx_full_d = 1'b1;
        end else if (rx_pop) begin
            rx_full_d = 1'b0;
        end

        // Setting overrun takes priority over the status-read clear
        if (rx_valid && rx_full_q && !rx_pop) begin
            overrun_d = 1'b1;
        end else if (status_rd) begin
            overrun_d = 1'b0;
        end

        if (accept) dout_d = rdata;
    end

    // Control/status registers
    always_ff @(posedge clk or negedge Rst_n) begin
        if (!Rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            rx_byte_q <= 8'd0;
            rx_full_q <= 1'b0;
            overrun_q <= 1'b0;
            dout_q    <= 32'd0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            rx_byte_q <= rx_byte_d;
            rx_full_q <= rx_full_d;
            overrun_q <= overrun_d;
            dout_q    <= dout_d;
        end
    end

    // Data RAM byte-lane writes (contents survive reset)
    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (mem_en[i]) ram_q[ram_idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    // TX FIFO storage
    always_ff @(posedge clk) begin
        if (push) tx_mem_q[wr_ptr_q[TX_AW-1:0]] <= mem_din[7:0];
    end

endmodule
